// File: rtl/sort_collect.sv
// Byte-stream to 4-lane frame collector feeding the combinational sorter, double-buffered.
// Optional idle-timeout flush of partial frames is enabled by defining SORT_COLLECT_TIMEOUT_EN.
module sort_collect #(
    parameter int                WIDTH   = 8,
    parameter int                TIMEOUT = 16,
    parameter logic [WIDTH-1:0]  PAD     = 8'hFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic             out_valid,
    input  logic             out_ack,
    output logic [7:0]       frame_cnt,
    output logic             timeout
);

    typedef enum logic [1:0] {ST_EMPTY, ST_FILLING, ST_FULL} state_t;

    state_t           state_reg, state_next;
    logic [1:0]       idx_reg, idx_next;
    logic [WIDTH-1:0] slot_reg [4];
    logic [WIDTH-1:0] out_reg  [4];
    logic             out_valid_reg;
    logic [7:0]       frame_cnt_reg;
    logic             timeout_reg;
    logic             accept;
    logic             xfer;
    logic             flush;

    assign accept = in_valid && in_ready;
    assign xfer   = (state_reg == ST_FULL) && (!out_valid_reg || out_ack);

`ifdef SORT_COLLECT_TIMEOUT_EN
    logic [7:0] idle_cnt_reg;

    // Counts consecutive non-accept cycles while a partial frame is pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_reg <= '0;
        end else if (state_reg != ST_FILLING || accept || flush) begin
            idle_cnt_reg <= '0;
        end else begin
            idle_cnt_reg <= idle_cnt_reg + 8'd1;
        end
    end

    assign flush = (state_reg == ST_FILLING) && !accept
                   && (idle_cnt_reg == 8'(TIMEOUT - 1));
`else
    logic unused_params;
    assign unused_params = &{1'b0, PAD, 8'(TIMEOUT)};
    assign flush = 1'b0;
`endif

    // Shadow FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_EMPTY;
            idx_reg   <= 2'd0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    // Shadow FSM: next-state logic
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        case (state_reg)
            ST_EMPTY: begin
                if (accept) begin
                    state_next = ST_FILLING;
                    idx_next   = 2'd1;
                end
            end
            ST_FILLING: begin
                if (accept) begin
                    idx_next = idx_reg + 2'd1;
                    if (idx_reg == 2'd3) begin
                        state_next = ST_FULL;
                    end
                end else if (flush) begin
                    state_next = ST_FULL;
                    idx_next   = 2'd0;
                end
            end
            ST_FULL: begin
                if (xfer) begin
                    state_next = ST_EMPTY;
                end
            end
            default: begin
                state_next = ST_EMPTY;
                idx_next   = 2'd0;
            end
        endcase
    end

    // Shadow FSM: outputs
    always_comb begin
        in_ready = (state_reg != ST_FULL);
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slot
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_reg[gi] <= '0;
                end else if (accept && idx_reg == 2'(gi)) begin
                    slot_reg[gi] <= in_data;
                end else if (flush && idx_reg <= 2'(gi)) begin
                    slot_reg[gi] <= PAD;
                end
            end

            // Output lanes only move on a transfer so the sorter sees a stable frame.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_reg[gi] <= '0;
                end else if (xfer) begin
                    out_reg[gi] <= slot_reg[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            frame_cnt_reg <= 8'd0;
            timeout_reg   <= 1'b0;
        end else begin
            timeout_reg <= flush;
            if (xfer) begin
                out_valid_reg <= 1'b1;
                frame_cnt_reg <= frame_cnt_reg + 8'd1;
            end else if (out_ack) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign a         = out_reg[0];
    assign b         = out_reg[1];
    assign c         = out_reg[2];
    assign d         = out_reg[3];
    assign out_valid = out_valid_reg;
    assign frame_cnt = frame_cnt_reg;
    assign timeout   = timeout_reg;

endmodule
